clk_divider: RTL and testbench
==============================

# clk_divider

Integer clock divider that derives a slow, nearly 50%-duty clock from the system clock. It is parameterised by input and output frequency in hertz. Its main consumer is the UART transmitter, which uses it to generate the baud-rate clock, e.g. 9600 Bd from 12 MHz. It also provides a one-cycle tick on each output rising edge for logic that stays in the system clock domain.

## Interface
- FREQ_IN, default 12000000: frequency of clk_in in Hz; positive integer.
- FREQ_OUT, default 9600: target frequency of clk_out in Hz; positive integer, FREQ_OUT <= FREQ_IN/2.
- clk_in  input  1  system clock; all logic is on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low; one clock, no other clock domains.
- clk_out  output  1  divided clock, registered, glitch-free.
- tick  output  1  one-clk_in-cycle pulse, high in the first cycle that clk_out is high.

## Operation
- Derived constants, computed at elaboration:
  - DIV = (FREQ_IN + FREQ_OUT/2) / FREQ_OUT, integer division, i.e. rounded to nearest.
  - LOW = DIV - DIV/2, the ceiling half.
  - HIGH = DIV/2, the floor half.
- Defaults give DIV=1250, LOW=625, HIGH=625.
- Elaboration must fail (fatal assertion) if FREQ_OUT = 0, FREQ_IN = 0 or DIV < 2.
- Counter width is $clog2(DIV) bits. The counter holds values 0..DIV-1 and wraps from DIV-1 to 0.
- Every clk_in rising edge with rst_n high:
  - count <= (count == DIV-1) ? 0 : count+1.
  - clk_out <= (next count >= LOW).
  - tick <= (next count == LOW).
- No states beyond the counter:
  - Phase LOW: count 0..LOW-1, clk_out=0.
  - Phase HIGH: count LOW..DIV-1, clk_out=1.
- For odd DIV the low phase is one cycle longer than the high phase.
- Average output frequency is FREQ_IN/DIV. Rounding error is not compensated; no fractional accumulation.
- The block has no enable input and runs continuously out of reset.

## Timing
- Reset: while rst_n=0, count=0, clk_out=0 and tick=0, applied immediately on the falling edge of rst_n, independent of clk_in.
- Reset mid-period: the period is truncated. After release the divider restarts from count 0, with no partial-high glitch.
- After rst_n deasserts, clk_out first goes to 1 on the LOW-th clk_in rising edge. With defaults that is edge 625.
- clk_out returns to 0 on edge DIV (defaults: edge 1250) and repeats with period DIV edges thereafter.
- tick is high for exactly one clk_in cycle, aligned with the clk_out 0->1 transition. It pulses once per DIV cycles.
- Both outputs change only on clk_in rising edges or on asynchronous reset. There is no combinational path from inputs to outputs.
- Downstream logic using clk_out as a clock accepts a phase offset of one clk_in register delay.

## Test plan
- Defaults, release reset, run 5000 cycles:
  - clk_out rises at edges 625, 1875, 3125 and 4375, falls at edges 1250, 2500 and 3750.
  - tick is high exactly in cycles 625, 1875, 3125 and 4375.
- FREQ_IN=10, FREQ_OUT=3, so DIV=3 (odd, rounded):
  - clk_out pattern per period is 0,0,1.
  - tick is high in the third cycle of each period; the period is 3 cycles.
- FREQ_IN=100, FREQ_OUT=50, so DIV=2 (minimum): clk_out toggles every cycle, 0,1,0,1…, and tick is high whenever clk_out is 1.
- Assert rst_n=0 mid-high-phase, asynchronously between clk_in edges:
  - clk_out and tick drop to 0 immediately.
  - After release, the first rising edge of clk_out is LOW edges later.
- FREQ_OUT=FREQ_IN (DIV=1) or FREQ_OUT=0: elaboration terminates with a fatal error.
- Defaults, measure over 100 output periods: every period is exactly 1250 clk_in cycles with high time 625, giving an average frequency of 9600 Hz.

Source files
------------

// File: rtl/clk_divider.sv
// ---------------------------------------------------------------------------
// clk_divider
//
// Integer clock divider. Derives a nearly 50%-duty clock from clk_in at
// FREQ_IN / DIV, where DIV = round(FREQ_IN / FREQ_OUT). Also produces a
// one-cycle tick, in the clk_in domain, on every rising edge of clk_out.
//
// Parameters:
//   FREQ_IN   frequency of clk_in in Hz (positive)
//   FREQ_OUT  target frequency of clk_out in Hz (positive, <= FREQ_IN/2)
//
// Ports:
//   clk_in   in   system clock; all logic runs on its rising edge
//   rst_n    in   asynchronous active-low reset
//   clk_out  out  divided clock, registered, glitch-free
//   tick     out  high for the first clk_in cycle in which clk_out is high
// ---------------------------------------------------------------------------
module clk_divider #(
    parameter int FREQ_IN  = 12000000,
    parameter int FREQ_OUT = 9600
) (
    input  logic clk_in,
    input  logic rst_n,
    output logic clk_out,
    output logic tick
);

    // Guard the division so a zero FREQ_OUT reaches the fatal check below
    // rather than failing on a divide-by-zero first.
    localparam int DIV   = (FREQ_OUT > 0) ? (FREQ_IN + FREQ_OUT / 2) / FREQ_OUT : 0;
    // Low phase takes the ceiling half, so odd DIV gives the extra cycle to
    // the low phase; the high phase is DIV - LOW cycles.
    localparam int LOW   = DIV - DIV / 2;
    localparam int CNT_W = (DIV < 2) ? 1 : $clog2(DIV);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LOW  = CNT_W'(LOW);

    if (FREQ_IN <= 0 || FREQ_OUT <= 0 || DIV < 2) begin : g_bad_params
        $fatal(1, "clk_divider: FREQ_IN and FREQ_OUT must be positive and give DIV >= 2");
    end

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_clk_out;
    logic             r_tick;

    always_comb begin
        w_cnt_nxt = (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
    end

    // Outputs are decoded from the next count so they change on the same
    // edge as the counter, with no extra cycle of latency.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_clk_out <= (w_cnt_nxt >= CNT_LOW);
            r_tick    <= (w_cnt_nxt == CNT_LOW);
        end
    end

    assign clk_out = r_clk_out;
    assign tick    = r_tick;

endmodule

// File: tb/tb_clk_divider.sv
// ---------------------------------------------------------------------------
// tb_clk_divider
//
// Runs three divider configurations (defaults, odd DIV=3, minimum DIV=2)
// from one clock and one reset. A reference model derives the expected
// outputs from the number of clk_in edges since reset release: clk_out is
// high when (edges mod DIV) >= LOW, tick when (edges mod DIV) == LOW.
// ---------------------------------------------------------------------------
module tb_clk_divider;

    localparam int FI0 = 12000000, FO0 = 9600;
    localparam int FI1 = 10,       FO1 = 3;
    localparam int FI2 = 100,      FO2 = 50;

    localparam int D0 = (FI0 + FO0 / 2) / FO0;
    localparam int L0 = D0 - D0 / 2;
    localparam int D1 = (FI1 + FO1 / 2) / FO1;
    localparam int L1 = D1 - D1 / 2;
    localparam int D2 = (FI2 + FO2 / 2) / FO2;
    localparam int L2 = D2 - D2 / 2;

    logic clk_in = 1'b0;
    logic rst_n  = 1'b0;
    logic clk_def, tick_def, clk_odd, tick_odd, clk_min, tick_min;

    clk_divider u_def (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .clk_out(clk_def),
        .tick   (tick_def)
    );

    clk_divider #(.FREQ_IN(FI1), .FREQ_OUT(FO1)) u_odd (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .clk_out(clk_odd),
        .tick   (tick_odd)
    );

    clk_divider #(.FREQ_IN(FI2), .FREQ_OUT(FO2)) u_min (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .clk_out(clk_min),
        .tick   (tick_min)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int exp_clk(input int e, input int d, input int l);
        return ((e % d) >= l) ? 1 : 0;
    endfunction

    function automatic int exp_tick(input int e, input int d, input int l);
        return ((e % d) == l) ? 1 : 0;
    endfunction

    // Edges since the last reset release.
    int n = 0;
    always @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) n <= 0;
        else        n <= n + 1;
    end

    bit   mon_en = 0;
    bit   rec_en = 0;
    logic prev0  = 1'b0;
    int   q_rise[$];
    int   q_fall[$];
    int   q_tick[$];

    always @(negedge clk_in) begin
        if (mon_en) begin
            if (!rst_n) begin
                check("rst_clk_def",  clk_def,  0);
                check("rst_tick_def", tick_def, 0);
                check("rst_clk_odd",  clk_odd,  0);
                check("rst_tick_odd", tick_odd, 0);
                check("rst_clk_min",  clk_min,  0);
                check("rst_tick_min", tick_min, 0);
            end else begin
                check("clk_def",  clk_def,  exp_clk (n, D0, L0));
                check("tick_def", tick_def, exp_tick(n, D0, L0));
                check("clk_odd",  clk_odd,  exp_clk (n, D1, L1));
                check("tick_odd", tick_odd, exp_tick(n, D1, L1));
                check("clk_min",  clk_min,  exp_clk (n, D2, L2));
                check("tick_min", tick_min, exp_tick(n, D2, L2));
            end
            if (rec_en && rst_n) begin
                if (clk_def === 1'b1 && prev0 === 1'b0) q_rise.push_back(n);
                if (clk_def === 1'b0 && prev0 === 1'b1) q_fall.push_back(n);
                if (tick_def === 1'b1)                  q_tick.push_back(n);
            end
            prev0 = clk_def;
        end
    end

    task automatic release_rst();
        @(posedge clk_in);
        #7 rst_n = 1'b1;
    endtask

    task automatic check_all_low(input string tag);
        check({tag, "_clk_def"},  clk_def,  0);
        check({tag, "_tick_def"}, tick_def, 0);
        check({tag, "_clk_odd"},  clk_odd,  0);
        check({tag, "_tick_odd"}, tick_odd, 0);
        check({tag, "_clk_min"},  clk_min,  0);
        check({tag, "_tick_min"}, tick_min, 0);
    endtask

    int exp_rise[4] = '{625, 1875, 3125, 4375};
    int exp_fall[3] = '{1250, 2500, 3750};

    initial begin
        int  first;
        int  off;
        int  nmin;
        longint total;

        // Reset state
        repeat (3) @(posedge clk_in);
        #1 check_all_low("reset");
        mon_en = 1;

        // Long run at defaults: 20 full output periods plus part of a high phase
        release_rst();
        rec_en = 1;
        repeat (25700) @(posedge clk_in);
        rec_en = 0;
        #2 check("pre_rst_high_def", clk_def, 1);
        // Asynchronous reset in the middle of the high phase
        #1 rst_n = 1'b0;
        #1 check_all_low("async_rst");

        check("rise_count", q_rise.size(), 21);
        check("fall_count", q_fall.size(), 20);
        check("tick_count", q_tick.size(), 21);
        if (q_rise.size() >= 4 && q_tick.size() >= 4)
            for (int i = 0; i < 4; i++) begin
                check("rise_edge", q_rise[i], exp_rise[i]);
                check("tick_edge", q_tick[i], exp_rise[i]);
            end
        if (q_fall.size() >= 3)
            for (int i = 0; i < 3; i++) check("fall_edge", q_fall[i], exp_fall[i]);
        for (int i = 1; i < q_rise.size(); i++)
            check("period", q_rise[i] - q_rise[i-1], 1250);
        nmin = (q_rise.size() < q_fall.size()) ? q_rise.size() : q_fall.size();
        for (int i = 0; i < nmin; i++)
            check("high_time", q_fall[i] - q_rise[i], 625);
        if (q_rise.size() >= 2) begin
            total = longint'(q_rise[q_rise.size()-1] - q_rise[0]);
            check("avg_freq_hz", 32'(longint'(FI0) * longint'(q_rise.size() - 1) / total), 9600);
        end

        // First rise after release comes LOW edges later
        repeat ($urandom_range(1, 5)) @(posedge clk_in);
        #7 rst_n = 1'b1;
        first = -1;
        for (int i = 0; i < 1300 && first < 0; i++) begin
            @(negedge clk_in);
            if (tick_def === 1'b1) first = n;
        end
        check("first_rise_after_rst", first, L0);
        check("clk_def_at_first_tick", clk_def, 1);

        // Random asynchronous resets at random phases
        for (int k = 0; k < 12; k++) begin
            repeat ($urandom_range(1, 40)) @(posedge clk_in);
            off = $urandom_range(1, 8);
            if (off >= 5) off++;
            #(off) rst_n = 1'b0;
            #1 check_all_low("rand_rst");
            repeat ($urandom_range(1, 3)) @(posedge clk_in);
            #7 rst_n = 1'b1;
        end

        repeat (20) @(posedge clk_in);
        mon_en = 0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
